// File: rtl/fib_pkg.sv
// Shared constants, FSM state encoding and run-length clamp for the
// Fibonacci register-file sequencer.
package fib_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    W1   = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_e;

  // A run always writes both seeds and can never exceed the register file.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    if (len < 2)          return 2;
    else if (len > depth) return depth;
    else                  return len;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports, one debug read port, one
// synchronous write port and an asynchronous active-low clear of every entry.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr0_i,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the array before this cycle's write lands.
  assign rdata0_o   = mem_q[raddr0_i];
  assign rdata1_o   = mem_q[raddr1_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/fib_regfile_seq.sv
// Sequencer that seeds reg[0]/reg[1] and fills reg[i] = reg[i-2] + reg[i-1],
// presenting each step's operands and sum on a valid-qualified stream.
module fib_regfile_seq #(
  parameter int DATA_W = fib_pkg::DATA_W,
  parameter int ADDR_W = fib_pkg::ADDR_W,
  parameter int DEPTH  = fib_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] init_a,
  input  logic [DATA_W-1:0] init_b,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [ADDR_W-1:0] idx,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  import fib_pkg::*;

  localparam int LW = ADDR_W + 1;

  // Stream handshake: out_valid is a one-cycle qualifier with no ready;
  // a, b, c and idx are meaningful only while out_valid is high.

  state_e            state_q;
  logic              busy_q, valid_q, done_q;
  logic [DATA_W-1:0] seed_a_q, seed_b_q;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [ADDR_W-1:0] idx_q;
  logic [LW-1:0]     len_q, ptr_q, len_eff_d;

  logic [ADDR_W-1:0] ptr_lo, raddr0, raddr1, waddr;
  logic [DATA_W-1:0] rd0, rd1, sum, wdata;
  logic              we;

  assign len_eff_d = LW'(clamp_len(32'(len), 32'(DEPTH)));
  assign ptr_lo    = ptr_q[ADDR_W-1:0];
  assign raddr0    = ptr_lo - ADDR_W'(2);
  assign raddr1    = ptr_lo - ADDR_W'(1);
  // Carry out is dropped: the sum wraps modulo 2^DATA_W.
  assign sum       = rd0 + rd1;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    unique case (state_q)
      W0: begin
        we    = 1'b1;
        waddr = ADDR_W'(0);
        wdata = seed_a_q;
      end
      W1: begin
        we    = 1'b1;
        waddr = ADDR_W'(1);
        wdata = seed_b_q;
      end
      RUN: begin
        we    = 1'b1;
        waddr = ptr_lo;
        wdata = sum;
      end
      default: ;
    endcase
  end

  reg_file #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_reg_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .raddr0_i   (raddr0),
    .rdata0_o   (rd0),
    .raddr1_i   (raddr1),
    .rdata1_o   (rd1),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      seed_a_q <= '0;
      seed_b_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            seed_a_q <= init_a;
            seed_b_q <= init_b;
            len_q    <= len_eff_d;
            busy_q   <= 1'b1;
            state_q  <= W0;
          end
        end
        W0: state_q <= W1;
        W1: begin
          ptr_q <= LW'(2);
          if (len_q == LW'(2)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= rd0;
          b_q     <= rd1;
          c_q     <= sum;
          idx_q   <= ptr_lo;
          valid_q <= 1'b1;
          if (ptr_q == len_q - LW'(1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            ptr_q <= ptr_q + LW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign done      = done_q;
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign idx       = idx_q;

endmodule

// File: tb/tb_fib_regfile_seq.sv
// Directed bench for fib_regfile_seq: a reference model fills an expected
// stream queue and register image at each start; a monitor checks the stream.
module tb_fib_regfile_seq;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int EW    = AW + 3 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] init_a = '0;
  logic [DW-1:0] init_b = '0;
  logic [AW:0]   len = '0;
  logic          busy, out_valid, done;
  logic [DW-1:0] a, b, c, dbg_data;
  logic [AW-1:0] idx;
  logic [AW-1:0] dbg_addr = '0;

  fib_regfile_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .init_a    (init_a),
    .init_b    (init_b),
    .len       (len),
    .busy      (busy),
    .out_valid (out_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .idx       (idx),
    .done      (done),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            start_cyc = 0;
  int            done_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mdl_mem [DEPTH];

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- stream monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (done === 1'b1) done_cnt++;
    if (out_valid !== 1'b0) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_valid: observed idx %0d, expected no valid", idx);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stream_idx", 32'(idx), 32'(e[EW-1 -: AW]));
        check("stream_a", a, e[3*DW-1 -: DW]);
        check("stream_b", b, e[2*DW-1 -: DW]);
        check("stream_c", c, e[DW-1:0]);
        check("valid_latency", 32'(cyc - start_cyc), 32'(idx) + 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_run(input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                           input int l, output int le);
    le = (l < 2) ? 2 : (l > DEPTH) ? DEPTH : l;
    mdl_mem[0] = a0;
    mdl_mem[1] = b0;
    for (int i = 2; i < le; i++) begin
      mdl_mem[i] = mdl_mem[i-2] + mdl_mem[i-1];
      exp_q.push_back({AW'(i), mdl_mem[i-2], mdl_mem[i-1], mdl_mem[i]});
    end
    @(negedge clk);
    init_a = a0;
    init_b = b0;
    len    = (AW+1)'(l);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Waits for done (bounded); optionally pulses start mid-run or resets at
  // the step whose idx equals abort_idx.
  task automatic wait_done(input int le, input int inject_at, input int abort_idx);
    int done_edge;
    done_edge = -1;
    for (int k = 1; k <= le + 8 && done_edge < 0; k++) begin
      @(posedge clk);
      #1;
      if (start) start = 1'b0;
      if (k == inject_at) begin
        init_a = 32'h55;
        init_b = 32'h77;
        start  = 1'b1;
      end
      if (abort_idx >= 0 && out_valid === 1'b1 && int'(idx) == abort_idx) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_a", a, 32'd0);
        check("abort_b", b, 32'd0);
        check("abort_c", c, 32'd0);
        check("abort_idx", 32'(idx), 32'd0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        return;
      end
      if (done === 1'b1) done_edge = k;
    end
    check("done_edge", 32'(done_edge), 32'(le));
    @(posedge clk);
    #1;
    check("busy_fall", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = AW'(i);
      #1;
      check(tag, dbg_data, mdl_mem[i]);
    end
  endtask

  task automatic peek(input string tag, input int addr, input logic [DW-1:0] exp);
    dbg_addr = AW'(addr);
    #1;
    check(tag, dbg_data, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int le;
    int done_before;
    logic [DW-1:0] ra, rb;

    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_c", c, 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check_mem("rst_mem");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run
    start_run(32'd0, 32'd1, 10, le);
    wait_done(le, -1, -1);
    check_mem("basic_mem");
    peek("basic_reg9", 9, 32'd34);

    // Overflow wraps
    start_run(32'hFFFF_FFFF, 32'd1, 3, le);
    wait_done(le, -1, -1);
    check_mem("ovf_mem");
    peek("ovf_reg2", 2, 32'd0);

    // len=0 clamps to 2: seeds only, higher registers untouched
    start_run(32'hA5A5_0001, 32'h3C3C_0002, 0, le);
    wait_done(le, -1, -1);
    check_mem("len0_mem");

    // len=40 clamps to DEPTH
    start_run(32'd0, 32'd1, 40, le);
    wait_done(le, -1, -1);
    check_mem("len40_mem");
    peek("len40_reg31", 31, 32'd1346269);

    // Start while busy is ignored
    done_before = done_cnt;
    start_run(32'd0, 32'd1, 10, le);
    wait_done(le, 4, -1);
    repeat (4) @(posedge clk);
    #1;
    check("busy_start_idle", 32'(busy), 32'd0);
    check("busy_start_done_cnt", 32'(done_cnt - done_before), 32'd1);
    check_mem("busy_start_mem");

    // Random seeds and length
    ra = $urandom();
    rb = $urandom();
    start_run(ra, rb, $urandom_range(3, 20), le);
    wait_done(le, -1, -1);
    check_mem("rand_mem");

    // Reset mid-run at idx=5
    done_before = done_cnt;
    start_run(32'd0, 32'd1, 10, le);
    wait_done(le, -1, 5);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - done_before), 32'd0);
    check_mem("abort_mem");
    @(negedge clk);
    rst_n = 1'b1;
    start_run(32'd2, 32'd3, 6, le);
    wait_done(le, -1, -1);
    check_mem("fresh_mem");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
